// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a 16x8 dual-port synchronous RAM.
// Converts push/pop requests into RAM write/read strobes and addresses, and
// tracks occupancy, full/empty/almost flags, sticky errors and read-valid.
module fifo_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    // Thresholds resized to the count width so comparisons are width-matched.
    localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_TH);
    localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_TH);
    localparam logic [ADDR_SIZE:0] ONE_C    = (ADDR_SIZE+1)'(1);

    // Pointers carry one extra MSB that toggles on every address wrap, which
    // lets full and empty be told apart when the address bits match.
    logic [ADDR_SIZE:0] wr_ptr_r;
    logic [ADDR_SIZE:0] rd_ptr_r;
    logic               rd_valid_r;
    logic               overflow_r;
    logic               underflow_r;

    logic               full_s;
    logic               empty_s;
    logic               write_s;
    logic               read_s;
    logic [ADDR_SIZE:0] count_s;

    // Derive flags from the registered pointers and gate requests with them.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[ADDR_SIZE-1:0] == rd_ptr_r[ADDR_SIZE-1:0]) &&
                  (wr_ptr_r[ADDR_SIZE] != rd_ptr_r[ADDR_SIZE]);
        count_s = wr_ptr_r - rd_ptr_r;
        write_s = push & ~full_s;
        read_s  = pop & ~empty_s;
    end

    // Advance the write pointer on every accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
        end else if (write_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Advance the read pointer on every accepted pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= '0;
        end else if (read_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // The RAM registers data_out on the accepting edge, so valid follows by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= read_s;
        end
    end

    // Sticky overflow: a fresh push-while-full wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (push && full_s) begin
            overflow_r <= 1'b1;
        end else if (err_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Sticky underflow: a fresh pop-while-empty wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow_r <= 1'b0;
        end else if (pop && empty_s) begin
            underflow_r <= 1'b1;
        end else if (err_clr) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign ram_write    = write_s;
    assign ram_read     = read_s;
    assign wr_addr      = wr_ptr_r[ADDR_SIZE-1:0];
    assign rd_addr      = rd_ptr_r[ADDR_SIZE-1:0];
    assign rd_valid     = rd_valid_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_s;
    assign almost_full  = (count_s >= AFULL_C);
    assign almost_empty = (count_s <= AEMPTY_C);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table-driven vectors, hand-written corner sequences and random
// traffic, all checked against a queue-based FIFO model with a local RAM model.
module tb_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic          ram_write;
    logic          ram_read;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    fifo_ctrl #(.ADDR_SIZE(AW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .err_clr(err_clr),
        .ram_write(ram_write), .ram_read(ram_read),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 RAM with registered read, driven by the DUT strobes.
    logic [7:0] din;
    logic [7:0] data_out;
    logic [7:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_write) mem[wr_addr] <= din;
        if (ram_read)  data_out <= mem[rd_addr];
    end

    // Reference model: contents queue, total push/pop counts, sticky flags.
    logic [7:0] q[$];
    int         m_wr, m_rd;
    bit         m_ovf, m_unf, m_rv;
    logic [7:0] m_data;
    logic [7:0] next_data;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        bit p, o, c;     // push, pop, err_clr
        bit w, r;        // expected ram_write, ram_read before the edge
        int cnt;         // expected count after the edge
        bit f, e, ov, un;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0; m_rv = 0; m_data = 8'h00;
    endtask

    task automatic add(input bit p, input bit o, input bit c, input bit w, input bit r,
                       input int cnt, input bit f, input bit e, input bit ov, input bit un);
        vec_t v;
        v.p = p; v.o = o; v.c = c; v.w = w; v.r = r;
        v.cnt = cnt; v.f = f; v.e = e; v.ov = ov; v.un = un;
        tbl.push_back(v);
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic do_cycle(input bit p, input bit o, input bit c, output bit sw, output bit sr);
        int sz;
        bit aw, ar;
        @(negedge clk);
        push = p; pop = o; err_clr = c; din = next_data;
        if (p) next_data = next_data + 8'd1;
        #1;
        sz = q.size();
        aw = p && (sz < DEPTH);
        ar = o && (sz > 0);
        chk("count", int'(count), sz);
        chk("full", int'(full), int'(sz == DEPTH));
        chk("empty", int'(empty), int'(sz == 0));
        chk("almost_full", int'(almost_full), int'(sz >= 14));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
        chk("wr_addr", int'(wr_addr), m_wr % DEPTH);
        chk("rd_addr", int'(rd_addr), m_rd % DEPTH);
        chk("rd_valid", int'(rd_valid), int'(m_rv));
        if (m_rv) chk("data_out", int'(data_out), int'(m_data));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
        chk("ram_write", int'(ram_write), int'(aw));
        chk("ram_read", int'(ram_read), int'(ar));
        sw = ram_write;
        sr = ram_read;
        @(posedge clk);
        if (ar) begin m_data = q.pop_front(); m_rd++; end
        if (aw) begin q.push_back(din); m_wr++; end
        m_rv = ar;
        if (p && sz == DEPTH) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (o && sz == 0)     m_unf = 1'b1; else if (c) m_unf = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_aempty"}, int'(almost_empty), 1);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
        chk({tag, "_ram_write"}, int'(ram_write), 0);
        chk({tag, "_ram_read"}, int'(ram_read), 0);
    endtask

    initial begin
        bit sw, sr;
        int wa, ra;

        // Vector table, walked from the reset state.
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);                      // pop while empty
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 1, 0, i + 1, i == 15, 0, 0, 1);        // fill
        add(1, 0, 0, 0, 0, 16, 1, 0, 1, 1);                     // 17th push
        add(1, 1, 0, 0, 1, 15, 0, 0, 1, 1);                     // push+pop at full
        add(0, 0, 1, 0, 0, 15, 0, 0, 0, 0);                     // err_clr
        add(1, 0, 0, 1, 0, 16, 1, 0, 0, 0);                     // refill
        add(1, 0, 1, 0, 0, 16, 1, 0, 1, 0);                     // clr + push-while-full
        for (int i = 0; i < 16; i++)
            add(0, 1, 0, 0, 1, 15 - i, 0, i == 15, 1, 0);       // drain
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);                      // 17th pop
        add(1, 1, 0, 1, 0, 1, 0, 0, 1, 1);                      // push+pop at empty
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);                      // err_clr

        reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = 8'h00;
        next_data = 8'h10;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("por");
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            do_cycle(tbl[i].p, tbl[i].o, tbl[i].c, sw, sr);
            chk("tbl_ram_write", int'(sw), int'(tbl[i].w));
            chk("tbl_ram_read", int'(sr), int'(tbl[i].r));
            #1;
            chk("tbl_count", int'(count), tbl[i].cnt);
            chk("tbl_full", int'(full), int'(tbl[i].f));
            chk("tbl_empty", int'(empty), int'(tbl[i].e));
            chk("tbl_overflow", int'(overflow), int'(tbl[i].ov));
            chk("tbl_underflow", int'(underflow), int'(tbl[i].un));
        end

        // Asynchronous reset mid-operation with count=5 and rd_valid high.
        repeat (5) do_cycle(1, 0, 0, sw, sr);
        do_cycle(0, 1, 0, sw, sr);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #1;
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_rd_valid", int'(rd_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Push+pop at count 8 for 10 cycles: count holds, both addresses advance 10.
        repeat (8) do_cycle(1, 0, 0, sw, sr);
        #1;
        wa = int'(wr_addr);
        ra = int'(rd_addr);
        repeat (10) do_cycle(1, 1, 0, sw, sr);
        #1;
        chk("pp8_count", int'(count), 8);
        chk("pp8_wr_addr", int'(wr_addr), (wa + 10) % DEPTH);
        chk("pp8_rd_addr", int'(rd_addr), (ra + 10) % DEPTH);
        while (q.size() > 0) do_cycle(0, 1, 0, sw, sr);

        // Wrap integrity across the pointer MSB toggle.
        repeat (12) do_cycle(1, 0, 0, sw, sr);
        repeat (12) do_cycle(0, 1, 0, sw, sr);
        repeat (16) do_cycle(1, 0, 0, sw, sr);
        repeat (16) do_cycle(0, 1, 0, sw, sr);
        do_cycle(0, 0, 0, sw, sr);

        // Random traffic with shifting push/pop bias.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            do_cycle($urandom_range(99) < bias, $urandom_range(99) < (100 - bias),
                     $urandom_range(99) < 5, sw, sr);
        end
        do_cycle(0, 0, 0, sw, sr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that sits directly upstream of the 16x8 dual-port synchronous RAM. Together the two blocks form a 16-deep, 8-bit synchronous FIFO.
- Converts push/pop requests into the RAM's write/read strobes and wr_addr/rd_addr addresses.
- Maintains the occupancy count, full/empty/almost flags and sticky overflow/underflow errors.
- Generates a valid strobe that aligns with the RAM's registered data_out.

Parameters:
- ADDR_SIZE, 4: RAM address width; FIFO depth = 2**ADDR_SIZE.
- AFULL_TH, 14: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  input  1  rising-edge clock shared with the RAM
- reset  input  1  asynchronous, active-low reset
- push  input  1  request to write the current data_in (data path goes straight to the RAM)
- pop  input  1  request to read the next entry
- err_clr  input  1  synchronous clear of overflow/underflow
- ram_write  output  1  to RAM write
- ram_read  output  1  to RAM read
- wr_addr  output  ADDR_SIZE  to RAM wr_addr
- rd_addr  output  ADDR_SIZE  to RAM rd_addr
- rd_valid  output  1  RAM data_out holds a freshly popped word this cycle
- full  output  1  count == 2**ADDR_SIZE
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_TH
- almost_empty  output  1  count <= AEMPTY_TH
- count  output  ADDR_SIZE+1  current occupancy, 0..16
- overflow  output  1  sticky: push seen while full
- underflow  output  1  sticky: pop seen while empty

Behaviour:
- Pointers:
  - Internal wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide.
  - wr_addr and rd_addr are their low ADDR_SIZE bits, driven straight from registers.
  - Address wraps 15 -> 0; the pointer MSB toggles on wrap.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal AND MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
  - All flags are combinational from the registered pointers, so they update the cycle after the accepting edge.
- Accept rules (combinational on current-cycle flags):
  - ram_write = push & ~full.
  - ram_read = pop & ~empty.
- Pointer update: on each clk edge, wr_ptr += ram_write and rd_ptr += ram_read.
- Simultaneous push and pop:
  - Neither full nor empty: both are accepted and count is unchanged.
  - When full: pop is accepted, push is rejected (overflow sets), and count becomes 15.
  - When empty: push is accepted, pop is rejected (underflow sets), and count becomes 1.
- Same-address read/write never occurs: equal low bits imply empty or full, and either the read or the write is rejected.
- Read latency: the RAM registers data_out on the edge that accepts the pop. rd_valid is a register loaded with ram_read, so it is high exactly the cycle after each accepted pop, alongside valid data_out.
- overflow: set on a clk edge where push & full; holds until err_clr or reset.
- underflow: set on a clk edge where pop & empty; holds until err_clr or reset.
- err_clr:
  - Clears both error flags on the next edge.
  - A new error in the same cycle as err_clr wins: the flag stays set.
  - Does not affect the pointers.
- Reset (asserted low, asynchronous, any time including mid-burst):
  - Pointers = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0, wr_addr = rd_addr = 0, ram_write = ram_read = 0 while push/pop are low.
  - Deassertion is taken on the following clk edge; the first request is accepted on the first edge with reset high.
- RAM contents are not cleared by this block. Stale data is unreachable because reads are gated by empty.

Test Plan:
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, addrs=0, rd_valid=0. Assert reset low mid-operation with count=5: all outputs return to reset values immediately (asynchronous).
- Fill: 16 pushes of 0x10..0x1F:
  - wr_addr steps 0..15 then wraps to 0.
  - almost_full rises when count reaches 14.
  - full=1 at count=16.
  - A 17th push gives ram_write=0 and overflow=1, and count stays 16.
- Drain: 16 pops after fill:
  - Each rd_valid pulse is one cycle after its pop; RAM data_out reads 0x10..0x1F in order.
  - empty=1 after the last pop.
  - A 17th pop gives ram_read=0, underflow=1, and no rd_valid.
- Simultaneous push+pop:
  - At count=8 for 10 cycles: count stays 8, and both addresses advance by 10 (wrapping).
  - At full: count goes 16 -> 15, overflow sets.
  - At empty: count goes 0 -> 1, underflow sets, no rd_valid.
- Wrap integrity: push 12, pop 12, push 16, pop 16. Data order is preserved across the pointer-MSB wrap, and full/empty are correct at every step.
- err_clr:
  - With both errors set, err_clr gives overflow=underflow=0 next cycle.
  - err_clr together with push-while-full leaves overflow=1.
